aes_128_dec: RTL and testbench
==============================

AES_128_DEC -- requirements
Module: aes_128_dec

Interface
REQ-001 SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-002 SHALL have port rst, input, 1 bit: asynchronous, active-low reset.
REQ-003 SHALL have port in_valid, input, 1 bit: ciphertext and key on in_ct/in_key are valid.
REQ-004 SHALL have port in_ready, output, 1 bit: block can accept a new job.
REQ-005 SHALL have port in_ct, input, 128 bits: ciphertext; byte 0 (FIPS-197 order) on bits [127:120].
REQ-006 SHALL have port in_key, input, 128 bits: cipher key, same byte order.
REQ-007 SHALL have port out_valid, output, 1 bit: out_pt holds a completed plaintext.
REQ-008 SHALL have port out_ready, input, 1 bit: consumer accepts out_pt.
REQ-009 SHALL have port out_pt, output, 128 bits: recovered plaintext, same byte order.
REQ-010 SHALL have port busy, output, 1 bit: high in every state except IDLE.

Function
REQ-011 SHALL implement the AES-128 inverse cipher per FIPS-197 so that aes_128_dec(aes_128(p,k),k)=p for all p,k.
REQ-012 SHALL use FSM states IDLE, KEYEXP, INIT, ROUND, DONE.
REQ-013 SHALL accept a job on a rising edge with in_valid=1 and in_ready=1 (edge E0): capture in_ct/in_key, go IDLE->KEYEXP, round counter=1.
REQ-014 SHALL drive in_ready=1 only in IDLE; in_valid outside IDLE is ignored, never queued.
REQ-015 SHALL, in KEYEXP (edges E1..E10), advance a single 128-bit round-key register forward one step per edge (RotWord, SubWord, Rcon 01,02,04,08,10,20,40,80,1b,36), holding rk10 after E10, then go to INIT.
REQ-016 SHALL, at INIT (E11), load state=ct XOR rk10 and step the key register back to rk9 via the inverse key schedule (w[i]=w[i+4] XOR w[i+3] for column 1..3; column 0 uses SubWord(RotWord(new w3)) XOR Rcon).
REQ-017 SHALL, in ROUND (E12..E20, rounds 9..1), apply InvShiftRows, InvSubBytes, AddRoundKey(rk_r), InvMixColumns, and step the key register back once per edge.
REQ-018 SHALL, at E21 (final round), apply InvShiftRows, InvSubBytes, AddRoundKey(rk0) without InvMixColumns, register result into out_pt, set out_valid=1, go to DONE.
REQ-019 SHALL give fixed latency: out_valid rises exactly 21 rising edges after the accepting edge E0.
REQ-020 SHALL hold out_pt and out_valid stable in DONE until an edge with out_ready=1, then clear out_valid and return to IDLE (in_ready=1 the following cycle).
REQ-021 SHALL not change out_pt except at E21 of a job and at reset.
REQ-022 SHALL compute S-box and inverse S-box combinationally (16 inverse for state, 4 forward for key schedule), no extra pipeline stage.
REQ-023 SHALL treat round counter as 4 bits, values 1..10 in KEYEXP and 9..0 in ROUND; any unused FSM encoding returns to IDLE on the next edge.
REQ-024 SHALL ignore in_ct/in_key changes after E0; captured values alone determine the result.

Reset
REQ-025 SHALL, while rst=0, force FSM=IDLE, in_ready=1 is masked to 0, out_valid=0, busy=0, out_pt=0, key/state/counter registers=0, regardless of clk.
REQ-026 SHALL, after rst rises, present in_ready=1 from the first cycle; a reset mid-job abandons it with no out_valid pulse.

Verification
REQ-027 SHALL pass: key 000102030405060708090a0b0c0d0e0f, ct 69c4e0d86a7b0430d8cdb78070b4c55a -> out_pt 00112233445566778899aabbccddeeff, out_valid exactly 21 edges after E0.
REQ-028 SHALL pass: key 2b7e151628aed2a6abf7158809cf4f3c, ct 3925841d02dc09fbdc118597196a0b32 -> out_pt 3243f6a8885a308d313198a2e0370734.
REQ-029 SHALL pass: key 0, ct 66e94bd4ef8a2c3b884cfa59ca342b2e -> out_pt 0.
REQ-030 SHALL pass backpressure: out_ready=0 for 10 cycles after out_valid -> out_pt/out_valid stable, in_ready=0, in_valid pulses ignored; out_ready=1 -> IDLE, next job correct.
REQ-031 SHALL pass reset at E10: rst=0 one cycle -> out_valid=0, busy=0, out_pt=0; next job (REQ-027 vector) correct at E0+21.
REQ-032 SHALL pass back-to-back: 1000 random (p,k) encrypted by aes_128 then decrypted -> out_pt equals p every time.

Source files
------------

// File: rtl/aes_128_dec.sv
// AES-128 inverse cipher: iterative, one round per clock, key schedule run forward
// to rk10 and then walked back alongside the rounds. Fixed 21-edge latency.
//
// state  | meaning
// IDLE   | waiting for a job, in_ready high
// KEYEXP | round key stepped forward rk0 -> rk10, counter 1..10
// INIT   | initial AddRoundKey with rk10, key stepped back to rk9
// ROUND  | inverse rounds 9..1, final round when counter reaches 0
// DONE   | plaintext held on out_pt until out_ready
module aes_128_dec (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_ct,
  input  logic [127:0] in_key,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_pt,
  output logic         busy
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    KEYEXP = 3'd1,
    INIT   = 3'd2,
    ROUND  = 3'd3,
    DONE   = 3'd4
  } state_t;

  state_t       st, st_nxt;
  logic [3:0]   cnt;
  logic [127:0] rk, blk;
  logic [31:0]  rot_in, sw;
  logic [127:0] rk_fwd, rk_bwd, rnd;

  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] r, x;
    r = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) r = r ^ x;
      x = xt(x);
    end
    return r;
  endfunction

  // Multiplicative inverse as a^254; maps 0 to 0 as the S-box requires.
  function automatic logic [7:0] gf_inv(input logic [7:0] a);
    logic [7:0] r, p;
    r = 8'h01;
    p = a;
    for (int i = 0; i < 7; i++) begin
      p = gf_mul(p, p);
      r = gf_mul(r, p);
    end
    return r;
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] a);
    logic [7:0] x;
    x = gf_inv(a);
    return x ^ {x[6:0], x[7]} ^ {x[5:0], x[7:6]} ^ {x[4:0], x[7:5]} ^ {x[3:0], x[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [7:0] inv_sbox(input logic [7:0] s);
    return gf_inv({s[6:0], s[7]} ^ {s[4:0], s[7:5]} ^ {s[1:0], s[7:2]} ^ 8'h05);
  endfunction

  function automatic logic [7:0] rcon(input logic [3:0] n);
    case (n)
      4'd1:    return 8'h01;
      4'd2:    return 8'h02;
      4'd3:    return 8'h04;
      4'd4:    return 8'h08;
      4'd5:    return 8'h10;
      4'd6:    return 8'h20;
      4'd7:    return 8'h40;
      4'd8:    return 8'h80;
      4'd9:    return 8'h1b;
      4'd10:   return 8'h36;
      default: return 8'h00;
    endcase
  endfunction

  // Byte n of a block sits at bits [127-8n -: 8]; column c holds bytes 4c..4c+3.
  function automatic logic [127:0] inv_shift_rows(input logic [127:0] v);
    logic [127:0] o;
    o = '0;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        o[127-8*(r+4*c) -: 8] = v[127-8*(r+4*((c-r)&3)) -: 8];
    return o;
  endfunction

  function automatic logic [127:0] inv_sub_bytes(input logic [127:0] v);
    logic [127:0] o;
    o = '0;
    for (int i = 0; i < 16; i++)
      o[127-8*i -: 8] = inv_sbox(v[127-8*i -: 8]);
    return o;
  endfunction

  function automatic logic [127:0] inv_mix_columns(input logic [127:0] v);
    logic [127:0] o;
    logic [7:0]   a0, a1, a2, a3;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      a0 = v[127-32*c -: 8];
      a1 = v[119-32*c -: 8];
      a2 = v[111-32*c -: 8];
      a3 = v[103-32*c -: 8];
      o[127-32*c -: 8] = gf_mul(a0, 8'h0e) ^ gf_mul(a1, 8'h0b) ^ gf_mul(a2, 8'h0d) ^ gf_mul(a3, 8'h09);
      o[119-32*c -: 8] = gf_mul(a0, 8'h09) ^ gf_mul(a1, 8'h0e) ^ gf_mul(a2, 8'h0b) ^ gf_mul(a3, 8'h0d);
      o[111-32*c -: 8] = gf_mul(a0, 8'h0d) ^ gf_mul(a1, 8'h09) ^ gf_mul(a2, 8'h0e) ^ gf_mul(a3, 8'h0b);
      o[103-32*c -: 8] = gf_mul(a0, 8'h0b) ^ gf_mul(a1, 8'h0d) ^ gf_mul(a2, 8'h09) ^ gf_mul(a3, 8'h0e);
    end
    return o;
  endfunction

  // One set of four forward S-boxes serves both directions of the key walk:
  // forward uses the old w3, backward uses the recovered previous w3 (w3^w2).
  assign rot_in = (st == KEYEXP) ? rk[31:0] : (rk[63:32] ^ rk[31:0]);
  assign sw = {sbox(rot_in[23:16]), sbox(rot_in[15:8]), sbox(rot_in[7:0]), sbox(rot_in[31:24])}
              ^ {rcon(cnt), 24'h0};

  always_comb begin
    logic [31:0] n0, n1, n2;
    n0 = rk[127:96] ^ sw;
    n1 = rk[95:64] ^ n0;
    n2 = rk[63:32] ^ n1;
    rk_fwd = {n0, n1, n2, rk[31:0] ^ n2};
    rk_bwd = {rk[127:96] ^ sw, rk[95:64] ^ rk[127:96], rk[63:32] ^ rk[95:64], rk[31:0] ^ rk[63:32]};
  end

  assign rnd      = inv_sub_bytes(inv_shift_rows(blk)) ^ rk;
  assign in_ready = rst && (st == IDLE);
  assign busy     = (st != IDLE);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) st <= IDLE;
    else      st <= st_nxt;
  end

  always_comb begin
    st_nxt = IDLE;
    case (st)
      IDLE:    st_nxt = in_valid ? KEYEXP : IDLE;
      KEYEXP:  st_nxt = (cnt == 4'd10) ? INIT : KEYEXP;
      INIT:    st_nxt = ROUND;
      ROUND:   st_nxt = (cnt == 4'd0) ? DONE : ROUND;
      DONE:    st_nxt = out_ready ? IDLE : DONE;
      default: st_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt       <= 4'd0;
      rk        <= '0;
      blk       <= '0;
      out_pt    <= '0;
      out_valid <= 1'b0;
    end else begin
      case (st)
        IDLE: begin
          if (in_valid) begin
            blk <= in_ct;
            rk  <= in_key;
            cnt <= 4'd1;
          end
        end
        KEYEXP: begin
          rk <= rk_fwd;
          if (cnt != 4'd10) cnt <= cnt + 4'd1;
        end
        INIT: begin
          blk <= blk ^ rk;
          rk  <= rk_bwd;
          cnt <= 4'd9;
        end
        ROUND: begin
          if (cnt == 4'd0) begin
            out_pt    <= rnd;
            out_valid <= 1'b1;
          end else begin
            blk <= inv_mix_columns(rnd);
            rk  <= rk_bwd;
            cnt <= cnt - 4'd1;
          end
        end
        DONE: begin
          if (out_ready) out_valid <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_aes_128_dec.sv
// Bench for aes_128_dec: known-answer table, backpressure, mid-job reset and random
// round trips through an encryption model built independently of the DUT.
`timescale 1ns/1ps
module tb_aes_128_dec;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] in_ct;
  logic [127:0] in_key;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] out_pt;
  logic         busy;

  int checks = 0;
  int errors = 0;

  logic [7:0] sb [256];

  typedef struct {
    logic [127:0] ct;
    logic [127:0] key;
    logic [127:0] pt;
  } vec_t;

  vec_t kat [3];

  aes_128_dec dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_ct     (in_ct),
    .in_key    (in_key),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_pt    (out_pt),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #3ms;
    $display("FAIL watchdog expired: actual=hang required=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  // S-box built by walking the generator 3 and its inverse in lockstep.
  task automatic build_sbox();
    logic [7:0] p, q, x;
    p = 8'h01;
    q = 8'h01;
    do begin
      p = p ^ {p[6:0], 1'b0} ^ (p[7] ? 8'h1b : 8'h00);
      q = q ^ {q[6:0], 1'b0};
      q = q ^ {q[5:0], 2'b00};
      q = q ^ {q[3:0], 4'h0};
      if (q[7]) q = q ^ 8'h09;
      x = q ^ {q[6:0], q[7]} ^ {q[5:0], q[7:6]} ^ {q[4:0], q[7:5]} ^ {q[3:0], q[7:4]};
      sb[p] = x ^ 8'h63;
    end while (p != 8'h01);
    sb[0] = 8'h63;
  endtask

  function automatic logic [127:0] aes_enc(input logic [127:0] p, input logic [127:0] k);
    logic [31:0]  w [44];
    logic [31:0]  t;
    logic [7:0]   rc;
    logic [7:0]   s [16];
    logic [7:0]   u [16];
    logic [7:0]   a0, a1, a2, a3;
    logic [127:0] o;
    rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = k[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {sb[t[23:16]], sb[t[15:8]], sb[t[7:0]], sb[t[31:24]]} ^ {rc, 24'h0};
        rc = xt(rc);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int j = 0; j < 16; j++) s[j] = p[127-8*j -: 8] ^ w[j/4][31-8*(j%4) -: 8];
    for (int r = 1; r <= 10; r++) begin
      for (int j = 0; j < 16; j++) u[j] = sb[s[j]];
      for (int c = 0; c < 4; c++)
        for (int q = 0; q < 4; q++) s[q+4*c] = u[q+4*((c+q)%4)];
      if (r != 10) begin
        for (int c = 0; c < 4; c++) begin
          a0 = s[4*c]; a1 = s[4*c+1]; a2 = s[4*c+2]; a3 = s[4*c+3];
          s[4*c]   = xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3;
          s[4*c+1] = a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3;
          s[4*c+2] = a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3;
          s[4*c+3] = xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3);
        end
      end
      for (int j = 0; j < 16; j++) s[j] = s[j] ^ w[4*r + j/4][31-8*(j%4) -: 8];
    end
    o = '0;
    for (int j = 0; j < 16; j++) o[127-8*j -: 8] = s[j];
    return o;
  endfunction

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Issues one job and returns the plaintext plus the number of edges from the
  // accepting edge to out_valid. Inputs are scrambled right after acceptance.
  task automatic run_job(input logic [127:0] ct, input logic [127:0] key, input logic rdy,
                         output logic [127:0] pt, output int lat);
    int          guard;
    int          changes;
    logic [127:0] prev;
    guard = 0;
    while (!in_ready && guard < 100) begin
      @(posedge clk); #1;
      guard++;
    end
    chk("ready_before_job", in_ready, 1);
    in_ct     = ct;
    in_key    = key;
    in_valid  = 1'b1;
    out_ready = rdy;
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_ct    = rand128();
    in_key   = rand128();
    chk("busy_after_accept", {busy, in_ready}, 2'b10);
    prev    = out_pt;
    changes = 0;
    lat     = 0;
    while (!out_valid && lat < 60) begin
      @(posedge clk); #1;
      lat++;
      if (!out_valid && out_pt !== prev) changes++;
    end
    chk("out_pt_hold_during_job", changes, 0);
    pt = out_pt;
  endtask

  initial begin
    logic [127:0] pt, p, k;
    int           lat;
    int           seen;

    kat[0] = '{ct: 128'h69c4e0d86a7b0430d8cdb78070b4c55a, key: 128'h000102030405060708090a0b0c0d0e0f,
               pt: 128'h00112233445566778899aabbccddeeff};
    kat[1] = '{ct: 128'h3925841d02dc09fbdc118597196a0b32, key: 128'h2b7e151628aed2a6abf7158809cf4f3c,
               pt: 128'h3243f6a8885a308d313198a2e0370734};
    kat[2] = '{ct: 128'h66e94bd4ef8a2c3b884cfa59ca342b2e, key: 128'h0,
               pt: 128'h0};

    build_sbox();
    for (int i = 0; i < 3; i++) chk("model_kat", aes_enc(kat[i].pt, kat[i].key), kat[i].ct);

    // Reset with in_valid asserted: nothing may be accepted or signalled.
    rst       = 1'b0;
    in_valid  = 1'b1;
    in_ct     = kat[0].ct;
    in_key    = kat[0].key;
    out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_out_pt", out_pt, 0);
    in_valid = 1'b0;
    rst      = 1'b1;
    #1;
    chk("ready_after_rst", in_ready, 1);

    foreach (kat[i]) begin
      run_job(kat[i].ct, kat[i].key, 1'b1, pt, lat);
      chk("kat_latency", lat, 21);
      chk("kat_pt", pt, kat[i].pt);
      @(posedge clk); #1;
      out_ready = 1'b0;
      chk("kat_release", {out_valid, in_ready, busy}, 3'b010);
    end

    // Backpressure: result held for 10 cycles while stray requests are ignored.
    run_job(kat[0].ct, kat[0].key, 1'b0, pt, lat);
    chk("bp_latency", lat, 21);
    chk("bp_pt", pt, kat[0].pt);
    for (int i = 0; i < 10; i++) begin
      in_valid = 1'($urandom_range(0, 1));
      in_ct    = rand128();
      in_key   = rand128();
      @(posedge clk); #1;
      chk("bp_hold", {out_valid, in_ready, busy, out_pt}, {3'b101, kat[0].pt});
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("bp_release", {out_valid, in_ready}, 2'b01);
    run_job(kat[1].ct, kat[1].key, 1'b1, pt, lat);
    chk("bp_next_latency", lat, 21);
    chk("bp_next_pt", pt, kat[1].pt);
    @(posedge clk); #1;

    // Reset right after E10 abandons the job without any out_valid pulse.
    while (!in_ready) begin @(posedge clk); #1; end
    in_ct     = kat[0].ct;
    in_key    = kat[0].key;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    chk("e10_busy", busy, 1);
    rst = 1'b0;
    #1;
    chk("mid_rst_state", {out_valid, busy, in_ready}, 3'b000);
    chk("mid_rst_out_pt", out_pt, 0);
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    chk("mid_rst_ready", in_ready, 1);
    seen = 0;
    repeat (25) begin
      @(posedge clk); #1;
      if (out_valid || busy) seen++;
    end
    chk("mid_rst_no_pulse", seen, 0);
    run_job(kat[0].ct, kat[0].key, 1'b1, pt, lat);
    chk("post_rst_latency", lat, 21);
    chk("post_rst_pt", pt, kat[0].pt);

    // Random round trips, back to back with out_ready held high.
    for (int n = 0; n < 1000; n++) begin
      p = rand128();
      k = rand128();
      run_job(aes_enc(p, k), k, 1'b1, pt, lat);
      chk("rand_latency", lat, 21);
      chk("rand_pt", pt, p);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
